// File: rtl/regbus_pkg.sv
// ---------------------------------------------------------------------------
// regbus_pkg
// Shared definitions for the register-file bus: default address/data widths
// (also used by the regfile_* responders), the host command opcodes and the
// regbus_master state encoding.
//
// Optional feature macro: REGBUS_RMW_EN (adds the RMW_WR state).
// ---------------------------------------------------------------------------
package regbus_pkg;

  localparam int REGBUS_AW = 14;
  localparam int REGBUS_DW = 16;

  typedef enum logic [1:0] {
    OP_WR   = 2'd0,
    OP_RD   = 2'd1,
    OP_POLL = 2'd2,
    OP_RMW  = 2'd3
  } regbus_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_CHK,
    ST_GAP,
    ST_RESP
`ifdef REGBUS_RMW_EN
    , ST_RMW_WR
`endif
  } regbus_state_e;

  // Width of a counter that must hold values 0..max_val (at least 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/regbus_master.sv
// ---------------------------------------------------------------------------
// regbus_master
// Initiator for the register-file bus. Takes WRITE / READ / POLL / RMW
// commands over a valid/ready stream, runs the bus cycles and returns exactly
// one response per command, in order, with no command/response overlap.
//
// Optional feature macro: REGBUS_RMW_EN
//   defined   : op 3 = read, then write (rd & ~mask) | (data & mask)
//   undefined : op 3 is rejected with rsp_err=1, no bus activity
//
// Ports
//   clk, rst_n            bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op/addr/data/mask command fields, latched on accept
//   rsp_valid/rsp_ready   response handshake, held until accepted
//   rsp_data/rsp_err      read data (0 for WRITE), timeout/illegal-op flag
//   wr_en/rd_en           one-cycle bus strobes, never together
//   addr/write_data       bus address and write data, held when idle
//   read_data             shared combinational read mux from the regfiles
// ---------------------------------------------------------------------------
module regbus_master
  import regbus_pkg::*;
#(
  parameter int AW       = REGBUS_AW,
  parameter int DW       = REGBUS_DW,
  parameter int RD_LAT   = 0,
  parameter int POLL_MAX = 256,
  parameter int POLL_GAP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  input  logic [DW-1:0] cmd_mask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data
);

  localparam int ATT_W    = $clog2(POLL_MAX + 1);
  localparam int WAIT_MAX = (RD_LAT > POLL_GAP) ? RD_LAT : POLL_GAP;
  localparam int WAIT_W   = cnt_width(WAIT_MAX);

  localparam logic [ATT_W-1:0]  ATT_LAST = ATT_W'(POLL_MAX);
  localparam logic [WAIT_W-1:0] RD_LAST  = WAIT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  regbus_state_e     state_q, state_d, after_read;
  regbus_op_e        op_q;
  logic [DW-1:0]     cmd_data_q, cmd_mask_q;
  logic [ATT_W-1:0]  att_q;
  logic [WAIT_W-1:0] wait_q;

  logic accept, rd_done, poll_match, poll_done;

  assign accept = (state_q == ST_IDLE) && cmd_valid;

  // The read mux is sampled on the edge that ends the last read cycle:
  // the RD cycle itself when RD_LAT is 0, else the last RD_WAIT cycle.
  assign rd_done = ((state_q == ST_RD) && (RD_LAT == 0)) ||
                   ((state_q == ST_RD_WAIT) && (wait_q == RD_LAST));

  // The captured read value lives in rsp_data, so CHK compares against it.
  assign poll_match = ((rsp_data ^ cmd_data_q) & cmd_mask_q) == '0;
  assign poll_done  = poll_match || (att_q == ATT_LAST);

  // ------------------------------------------------------------------
  // Next-state and strobe decode
  // ------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;

    after_read = ST_RESP;
    if (op_q == OP_POLL) after_read = ST_CHK;
`ifdef REGBUS_RMW_EN
    if (op_q == OP_RMW) after_read = ST_RMW_WR;
`endif

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (regbus_op_e'(cmd_op))
            OP_WR:   state_d = ST_WR;
            OP_RD:   state_d = ST_RD;
            OP_POLL: state_d = ST_RD;
`ifdef REGBUS_RMW_EN
            OP_RMW:  state_d = ST_RD;
`else
            OP_RMW:  state_d = ST_RESP;
`endif
            default: state_d = ST_RESP;
          endcase
        end
      end
      ST_WR: begin
        wr_en   = 1'b1;
        state_d = ST_RESP;
      end
      ST_RD: begin
        rd_en   = 1'b1;
        state_d = (RD_LAT > 0) ? ST_RD_WAIT : after_read;
      end
      ST_RD_WAIT: begin
        if (wait_q == RD_LAST) state_d = after_read;
      end
      ST_CHK: begin
        if (poll_done)         state_d = ST_RESP;
        else if (POLL_GAP > 0) state_d = ST_GAP;
        else                   state_d = ST_RD;
      end
      ST_GAP: begin
        if (wait_q == GAP_LAST) state_d = ST_RD;
      end
`ifdef REGBUS_RMW_EN
      ST_RMW_WR: begin
        wr_en   = 1'b1;
        state_d = ST_RESP;
      end
`endif
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // State register. Strobes decode from state, so an async reset drops
  // any in-flight wr_en/rd_en immediately.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ------------------------------------------------------------------
  // Command latch, bus drivers, counters and response registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_WR;
      cmd_data_q <= '0;
      cmd_mask_q <= '0;
      addr       <= '0;
      write_data <= '0;
      att_q      <= '0;
      wait_q     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      // Shared wait counter: runs while parked in RD_WAIT or GAP, and
      // restarts from 0 on every state change.
      if ((state_d == state_q) &&
          ((state_q == ST_RD_WAIT) || (state_q == ST_GAP)))
        wait_q <= wait_q + WAIT_W'(1);
      else
        wait_q <= '0;

      if (accept) begin
        op_q       <= regbus_op_e'(cmd_op);
        cmd_data_q <= cmd_data;
        cmd_mask_q <= cmd_mask;
        addr       <= cmd_addr;
        att_q      <= '0;
        rsp_data   <= '0;
`ifdef REGBUS_RMW_EN
        rsp_err    <= 1'b0;
`else
        rsp_err    <= (regbus_op_e'(cmd_op) == OP_RMW);
`endif
        if (regbus_op_e'(cmd_op) == OP_WR) write_data <= cmd_data;
      end

      if (state_q == ST_RD) att_q <= att_q + ATT_W'(1);

      if (rd_done) begin
        rsp_data <= read_data;
`ifdef REGBUS_RMW_EN
        if (op_q == OP_RMW)
          write_data <= (read_data & ~cmd_mask_q) | (cmd_data_q & cmd_mask_q);
`endif
      end

      if ((state_q == ST_CHK) && !poll_match && (att_q == ATT_LAST))
        rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regbus_master.sv
// ---------------------------------------------------------------------------
// tb_regbus_master
// Two regbus_master instances share one regfile model and the command bus:
//   dut0: RD_LAT=0, POLL_MAX=4, POLL_GAP=4
//   dut1: RD_LAT=2, POLL_MAX=4, POLL_GAP=0
// Only the selected instance sees cmd_valid. A directed vector table, a few
// hand-written multi-cycle sequences (poll rise, back-pressure, reset
// mid-poll) and a random phase checked against a transaction-level model.
// Honours REGBUS_RMW_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_regbus_master;
  import regbus_pkg::*;

  localparam int AW       = 14;
  localparam int DW       = 16;
  localparam int POLL_MAX = 4;
  localparam int RD_LAT0  = 0;
  localparam int GAP0     = 4;
  localparam int RD_LAT1  = 2;
  localparam int GAP1     = 0;
  localparam int LIMIT    = 200;
  localparam logic [AW-1:0] POLL_ADDR = 14'h20a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data, cmd_mask;
  logic          rsp_ready;

  logic          cmd_valid0, cmd_ready0, rsp_valid0, rsp_err0, wr_en0, rd_en0;
  logic [DW-1:0] rsp_data0, write_data0, read_data0;
  logic [AW-1:0] addr0;
  logic          cmd_valid1, cmd_ready1, rsp_valid1, rsp_err1, wr_en1, rd_en1;
  logic [DW-1:0] rsp_data1, write_data1, read_data1;
  logic [AW-1:0] addr1;

  regbus_master #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT0), .POLL_MAX(POLL_MAX), .POLL_GAP(GAP0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0), .rsp_err(rsp_err0),
    .wr_en(wr_en0), .rd_en(rd_en0), .addr(addr0), .write_data(write_data0),
    .read_data(read_data0));

  regbus_master #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT1), .POLL_MAX(POLL_MAX), .POLL_GAP(GAP1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .wr_en(wr_en1), .rd_en(rd_en1), .addr(addr1), .write_data(write_data1),
    .read_data(read_data1));

  // Regfile model: plain array, written by the bench when it sees wr_en.
  // POLL_ADDR is a status register whose bit0 reads 1 from the 4th read on;
  // poll_reads is bumped mid rd_en cycle, before the sampling edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int poll_reads;

  always_comb begin
    read_data0 = (addr0 == POLL_ADDR) ? {{(DW-1){1'b0}}, (poll_reads >= 4)} : mem[addr0];
    read_data1 = mem[addr1];
  end

  int sel;
  logic          cur_cmd_ready, cur_rsp_valid, cur_rsp_err, cur_wr_en, cur_rd_en;
  logic [DW-1:0] cur_rsp_data, cur_write_data;
  logic [AW-1:0] cur_addr;

  always_comb begin
    if (sel == 1) begin
      cur_cmd_ready = cmd_ready1; cur_rsp_valid = rsp_valid1; cur_rsp_err = rsp_err1;
      cur_wr_en = wr_en1; cur_rd_en = rd_en1; cur_rsp_data = rsp_data1;
      cur_write_data = write_data1; cur_addr = addr1;
    end else begin
      cur_cmd_ready = cmd_ready0; cur_rsp_valid = rsp_valid0; cur_rsp_err = rsp_err0;
      cur_wr_en = wr_en0; cur_rd_en = rd_en0; cur_rsp_data = rsp_data0;
      cur_write_data = write_data0; cur_addr = addr0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            s;
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] m;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            exp_wr;
    int            exp_rd;
    int            exp_lat;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(input int s, input logic [1:0] op, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] m,
                              input logic [DW-1:0] exp_data, input logic exp_err,
                              input int exp_wr, input int exp_rd, input int exp_lat,
                              input logic [DW-1:0] exp_wdata);
    vec_t v;
    v.s = s; v.op = op; v.a = a; v.d = d; v.m = m;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_wr = exp_wr;
    v.exp_rd = exp_rd; v.exp_lat = exp_lat; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Transaction-level reference: what a command does to the bus and what
  // it returns, given the register contents before it starts.
  function automatic vec_t model(input int s, input logic [1:0] op, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [DW-1:0] m);
    int rl, gp, n;
    logic [DW-1:0] cur;
    logic match;
    vec_t v;
    rl  = (s == 1) ? RD_LAT1 : RD_LAT0;
    gp  = (s == 1) ? GAP1 : GAP0;
    cur = mem[a];
    v = mk(s, op, a, d, m, '0, 1'b0, 0, 0, 0, '0);
    if (op == OP_WR) begin
      v.exp_wr = 1; v.exp_lat = 2; v.exp_wdata = d;
    end else if (op == OP_RD) begin
      v.exp_data = cur; v.exp_rd = 1; v.exp_lat = 2 + rl;
    end else if (op == OP_POLL) begin
      match = ((cur & m) == (d & m));
      n = match ? 1 : POLL_MAX;
      v.exp_data = cur; v.exp_err = !match; v.exp_rd = n;
      v.exp_lat = 1 + n * (2 + rl) + (n - 1) * gp;
    end else begin
`ifdef REGBUS_RMW_EN
      v.exp_data = cur; v.exp_rd = 1; v.exp_wr = 1; v.exp_lat = 3 + rl;
      v.exp_wdata = (cur & ~m) | (d & m);
`else
      v.exp_err = 1'b1; v.exp_lat = 1;
`endif
    end
    return v;
  endfunction

  // Results of the last run_cmd (only the main initial process uses these).
  logic [DW-1:0] r_data, r_wdata;
  logic          r_err;
  logic [AW-1:0] r_waddr;
  int r_lat, r_nwr, r_nrd, r_addr_bad, r_excl_bad;
  int rd_cycles[$];

  task automatic run_cmd(input int s, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m, input int hold);
    int lat;
    r_nwr = 0; r_nrd = 0; r_addr_bad = 0; r_excl_bad = 0;
    r_waddr = '0; r_wdata = '0; rd_cycles.delete();
    @(negedge clk);
    sel = s; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    rsp_ready = (hold == 0);
    if (s == 1) cmd_valid1 = 1'b1; else cmd_valid0 = 1'b1;
    #1;
    check("cmd_ready_idle", 32'(cur_cmd_ready), 32'd1);
    @(negedge clk);
    // Scramble the command bus: the accepted command must be latched.
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = AW'($urandom);
    cmd_data = DW'($urandom); cmd_mask = DW'($urandom);
    lat = 1;
    while (!cur_rsp_valid && lat < LIMIT) begin
      if (cur_addr !== a) r_addr_bad++;
      if (cur_wr_en && cur_rd_en) r_excl_bad++;
      if (cur_wr_en) begin
        r_nwr++; r_waddr = cur_addr; r_wdata = cur_write_data;
        mem[cur_addr] = cur_write_data;
      end
      if (cur_rd_en) begin
        r_nrd++; rd_cycles.push_back(lat);
        if (cur_addr == POLL_ADDR && s == 0) poll_reads++;
      end
      @(negedge clk);
      lat++;
    end
    r_lat = lat;
    if (!cur_rsp_valid) begin
      check("rsp_timeout", 32'd0, 32'd1);
      rsp_ready = 1'b1;
      return;
    end
    r_data = cur_rsp_data;
    r_err  = cur_rsp_err;
    for (int i = 0; i < hold; i++) begin
      check("rsp_hold", {cur_rsp_valid, cur_cmd_ready, cur_wr_en, cur_rd_en, cur_rsp_err, cur_rsp_data},
            {1'b1, 1'b0, 1'b0, 1'b0, r_err, r_data});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_drop", {cur_rsp_valid, cur_cmd_ready}, 32'b01);
  endtask

  task automatic apply(input vec_t v, input int hold, input string tag);
    run_cmd(v.s, v.op, v.a, v.d, v.m, hold);
    check({tag, "_data"},  32'(r_data),     32'(v.exp_data));
    check({tag, "_err"},   32'(r_err),      32'(v.exp_err));
    check({tag, "_nwr"},   32'(r_nwr),      32'(v.exp_wr));
    check({tag, "_nrd"},   32'(r_nrd),      32'(v.exp_rd));
    check({tag, "_lat"},   32'(r_lat),      32'(v.exp_lat));
    check({tag, "_addr"},  32'(r_addr_bad), 32'd0);
    check({tag, "_excl"},  32'(r_excl_bad), 32'd0);
    if (v.exp_wr > 0) begin
      check({tag, "_waddr"}, 32'(r_waddr), 32'(v.a));
      check({tag, "_wdata"}, 32'(r_wdata), 32'(v.exp_wdata));
    end
  endtask

  // Start a never-matching POLL on dut0 and assert reset k cycles after
  // accept (cycle 1 = RD, 2 = CHK, 3..6 = GAP).
  task automatic reset_during(input int k, input string tag);
    int seen;
    @(negedge clk);
    sel = 0; cmd_op = OP_POLL; cmd_addr = 14'h203; cmd_data = 16'h0001; cmd_mask = 16'h0001;
    rsp_ready = 1'b1; cmd_valid0 = 1'b1;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    repeat (k - 1) @(negedge clk);
    check({tag, "_pre_rd_en"}, 32'(cur_rd_en), (k == 1) ? 32'd1 : 32'd0);
    rst_n = 1'b0;
    #1;
    check({tag, "_in_reset"}, {cur_wr_en, cur_rd_en, cur_rsp_valid, cur_rsp_err, cur_addr},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "_ready_after"}, 32'(cur_cmd_ready), 32'd1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (cur_rsp_valid || cur_rd_en || cur_wr_en) seen++;
    end
    check({tag, "_no_rsp"}, 32'(seen), 32'd0);
  endtask

  vec_t vecs[$];
  vec_t v;
  logic [1:0]    rop;
  logic [AW-1:0] ra;
  logic [DW-1:0] rdat, rmsk;
  int            rs;

  initial begin
    sel = 0; poll_reads = 0;
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[14'h209] = 16'h0042;
    mem[14'h204] = 16'h00F0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_dut0", {wr_en0, rd_en0, rsp_valid0, rsp_err0, addr0}, 32'd0);
    check("reset_dut0_data", {write_data0, rsp_data0}, 32'd0);
    check("reset_dut1", {wr_en1, rd_en1, rsp_valid1, rsp_err1, addr1}, 32'd0);
    check("reset_dut1_data", {write_data1, rsp_data1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {cmd_ready0, cmd_ready1}, 32'b11);

    // Directed vector table
    vecs.push_back(mk(0, OP_WR,   14'h201, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 1, 0, 2,  16'hBEEF));
    vecs.push_back(mk(0, OP_RD,   14'h201, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 0, 1, 2,  16'h0000));
    vecs.push_back(mk(0, OP_RD,   14'h209, 16'h0000, 16'h0000, 16'h0042, 1'b0, 0, 1, 2,  16'h0000));
    vecs.push_back(mk(1, OP_RD,   14'h209, 16'h0000, 16'h0000, 16'h0042, 1'b0, 0, 1, 4,  16'h0000));
    vecs.push_back(mk(0, OP_POLL, 14'h203, 16'h0001, 16'h0001, 16'h0000, 1'b1, 0, 4, 21, 16'h0000));
    vecs.push_back(mk(1, OP_POLL, 14'h203, 16'h0001, 16'h0001, 16'h0000, 1'b1, 0, 4, 17, 16'h0000));
    vecs.push_back(mk(1, OP_POLL, 14'h209, 16'h0042, 16'h00FF, 16'h0042, 1'b0, 0, 1, 5,  16'h0000));
`ifdef REGBUS_RMW_EN
    vecs.push_back(mk(0, OP_RMW,  14'h204, 16'h0005, 16'h000F, 16'h00F0, 1'b0, 1, 1, 3,  16'h00F5));
    vecs.push_back(mk(0, OP_RD,   14'h204, 16'h0000, 16'h0000, 16'h00F5, 1'b0, 0, 1, 2,  16'h0000));
`else
    vecs.push_back(mk(0, OP_RMW,  14'h204, 16'h0005, 16'h000F, 16'h0000, 1'b1, 0, 0, 1,  16'h0000));
    vecs.push_back(mk(0, OP_RD,   14'h204, 16'h0000, 16'h0000, 16'h00F0, 1'b0, 0, 1, 2,  16'h0000));
`endif
    vecs.push_back(mk(1, OP_WR,   14'h205, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1, 0, 2,  16'h1234));
    vecs.push_back(mk(0, OP_RD,   14'h205, 16'h0000, 16'h0000, 16'h1234, 1'b0, 0, 1, 2,  16'h0000));
    foreach (vecs[i]) apply(vecs[i], 0, $sformatf("vec%0d", i));

    // Poll on a status bit that rises on the 4th read (dut0)
    poll_reads = 0;
    apply(mk(0, OP_POLL, POLL_ADDR, 16'h0001, 16'h0001, 16'h0001, 1'b0, 0, 4, 21, 16'h0000),
          0, "poll_rise");
    if (rd_cycles.size() == 4) begin
      foreach (rd_cycles[i])
        check($sformatf("poll_rd_cycle%0d", i), 32'(rd_cycles[i]),
              32'(1 + i * (2 + RD_LAT0 + GAP0)));
    end

    // Response back-pressure for 10 cycles
    apply(mk(0, OP_RD, 14'h201, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 0, 1, 2, 16'h0000),
          10, "bp_rd");
    apply(mk(1, OP_WR, 14'h206, 16'hA5A5, 16'h0000, 16'h0000, 1'b0, 1, 0, 2, 16'hA5A5),
          10, "bp_wr");

    // Reset during GAP, then during the RD strobe cycle
    reset_during(4, "rst_gap");
    reset_during(1, "rst_rd");

    // Random commands against the transaction model
    for (int i = 0; i < 16; i++) mem[14'h210 + i] = DW'($urandom);
    for (int i = 0; i < 60; i++) begin
      rs   = int'($urandom_range(0, 1));
      rop  = 2'($urandom_range(0, 3));
      ra   = 14'h210 + AW'($urandom_range(0, 7));
      rmsk = DW'($urandom);
      rdat = DW'($urandom);
      if (rop == OP_POLL && $urandom_range(0, 1) == 1) rdat = mem[ra];
      v = model(rs, rop, ra, rdat, rmsk);
      apply(v, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
